mips16_core_param: RTL and testbench

Parametrised multi-cycle successor to the minimal 16-bit MIPS-style CPU in the tt_um_mips16 design.
- Loadable instruction memory with a write port.
- Eight-register file; r0 is hard-wired to zero.
- Configurable datapath width and instruction-memory depth.
- Ten-operation ALU with signed immediates, conditional branch, jump and halt.
- Start/busy/halted control and a write-back observation port, so the tile top can drive uo_out and testbenches can trace execution.

---
 rtl/mips16_core_param.sv | 138 +++++++++++++
 tb/tb_mips16_core_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips16_core_param.sv
// Parametrised multi-cycle MIPS-style core: 16-bit encodings, DW-bit datapath,
// loadable instruction memory, eight registers (r0 = 0), start/busy/halted control.
module mips16_core_param #(
  parameter int DW      = 16,
  parameter int IMEM_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               prog_we_i,
  input  logic [IMEM_AW-1:0] prog_addr_i,
  input  logic [15:0]        prog_data_i,
  output logic [DW-1:0]      result_o,
  output logic               wb_valid_o,
  output logic [2:0]         wb_rd_o,
  output logic [IMEM_AW-1:0] pc_o,
  output logic               busy_o,
  output logic               halted_o
);
  localparam int IMEM_DEPTH = 2 ** IMEM_AW;
  localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t             state_q;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [15:0]        ir_q;
  logic [15:0]        imem_q [IMEM_DEPTH];
  logic [DW-1:0]      rf_q [8];
  logic [DW-1:0]      result_q, alu_d;
  logic [2:0]         wb_rd_q;
  logic               wb_valid_q, wr_en_d;
  logic               busy_q, halted_q;

  logic [3:0]         op;
  logic [2:0]         rd, rs, rt;
  logic [DW-1:0]      rdVal, rsVal, rtVal, simm;
  logic [IMEM_AW-1:0] simmPc, brTarget;
  logic               progAllowed;

  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:9];
  assign rs    = ir_q[8:6];
  assign rt    = ir_q[5:3];
  assign rdVal = rf_q[rd];
  assign rsVal = rf_q[rs];
  assign rtVal = rf_q[rt];
  assign simm  = {{(DW-6){ir_q[5]}}, ir_q[5:0]};

  // Branch offset is sign-extended then truncated so targets wrap modulo the memory depth.
  assign simmPc   = IMEM_AW'({{10{ir_q[5]}}, ir_q[5:0]});
  assign brTarget = pc_q + PC_ONE + simmPc;

  assign progAllowed = (state_q == S_IDLE) || (state_q == S_HALT);

  // Memory has no reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we_i && progAllowed) imem_q[prog_addr_i] <= prog_data_i;
  end

  always_comb begin
    alu_d   = '0;
    wr_en_d = 1'b0;
    pc_d    = pc_q + PC_ONE;
    case (op)
      4'h0: begin alu_d = rsVal + rtVal; wr_en_d = 1'b1; end
      4'h1: begin alu_d = rsVal - rtVal; wr_en_d = 1'b1; end
      4'h2: begin alu_d = rsVal + simm;  wr_en_d = 1'b1; end
      4'h3: begin alu_d = rsVal & rtVal; wr_en_d = 1'b1; end
      4'h4: begin alu_d = rsVal | rtVal; wr_en_d = 1'b1; end
      4'h5: begin alu_d = rsVal ^ rtVal; wr_en_d = 1'b1; end
      4'h6: begin
        alu_d   = ($signed(rsVal) < $signed(rtVal)) ? DW'(1) : '0;
        wr_en_d = 1'b1;
      end
      4'h7: if (rdVal == rsVal) pc_d = brTarget;
      4'h8: pc_d = ir_q[IMEM_AW-1:0];
      4'hF: pc_d = pc_q;
      default: ;
    endcase
  end

  // rf_q[0] is never written, so r0 reads zero without a read-side mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      result_q   <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q    <= imem_q[pc_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          pc_q <= pc_d;
          if (op == 4'hF) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
          if (wr_en_d) begin
            result_q   <= alu_d;
            wb_rd_q    <= rd;
            wb_valid_q <= 1'b1;
            if (rd != 3'd0) rf_q[rd] <= alu_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign pc_o       = pc_q;
  assign busy_o     = busy_q;
  assign halted_o   = halted_q;

endmodule

// File: tb/tb_mips16_core_param.sv
// Directed bench for mips16_core_param: a DW=16 and a DW=8 core share stimulus,
// expected values are hand-computed from the instruction encodings.
module tb_mips16_core_param;
  logic        clk = 1'b0;
  logic        rst, start, progWe;
  logic [3:0]  progAddr;
  logic [15:0] progData;

  logic [15:0] result16;
  logic [7:0]  result8;
  logic        wbValid16, wbValid8, busy16, busy8, halted16, halted8;
  logic [2:0]  wbRd16, wbRd8;
  logic [3:0]  pc16, pc8;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] evRes[$];
  logic [31:0] evRd[$];
  int          evCyc[$];
  logic [31:0] evRes8[$];
  int          haltCyc;

  always #5 clk = ~clk;

  mips16_core_param #(.DW(16), .IMEM_AW(4)) dut16 (
    .clk(clk), .rst(rst), .start_i(start), .prog_we_i(progWe),
    .prog_addr_i(progAddr), .prog_data_i(progData),
    .result_o(result16), .wb_valid_o(wbValid16), .wb_rd_o(wbRd16),
    .pc_o(pc16), .busy_o(busy16), .halted_o(halted16)
  );

  mips16_core_param #(.DW(8), .IMEM_AW(4)) dut8 (
    .clk(clk), .rst(rst), .start_i(start), .prog_we_i(progWe),
    .prog_addr_i(progAddr), .prog_data_i(progData),
    .result_o(result8), .wb_valid_o(wbValid8), .wb_rd_o(wbRd8),
    .pc_o(pc8), .busy_o(busy8), .halted_o(halted8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [15:0] data);
    progWe   = 1'b1;
    progAddr = addr;
    progData = data;
    step();
    progWe   = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs from pc=0 until halted, logging write-backs with their cycle offset from the start edge.
  task automatic applyStimulus(input int maxCycles, input bit writeWhileBusy);
    evRes.delete(); evRd.delete(); evCyc.delete(); evRes8.delete();
    haltCyc = -1;
    pulseStart();
    for (int i = 1; i <= maxCycles && haltCyc < 0; i++) begin
      if (writeWhileBusy) begin
        progWe   = (i <= 3);
        progAddr = 4'd1;
        progData = 16'hF000;
      end
      step();
      if (wbValid16) begin
        evRes.push_back(32'(result16));
        evRd.push_back(32'(wbRd16));
        evCyc.push_back(i);
      end
      if (wbValid8) evRes8.push_back(32'(result8));
      if (halted16) haltCyc = i;
    end
    progWe = 1'b0;
  endtask

  task automatic checkArith();
    logic [31:0] expRes[3];
    logic [31:0] expRes8[3];
    expRes  = '{32'h0005, 32'hFFFD, 32'h0002};
    expRes8 = '{32'h05, 32'hFD, 32'h02};
    checkOutput("arith_wb_count", 32'(evRes.size()), 32'd3);
    if (evRes.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("arith_result", evRes[k], expRes[k]);
        checkOutput("arith_wb_rd", evRd[k], 32'(k + 1));
        checkOutput("arith_wb_cycle", 32'(evCyc[k]), 32'(2 * (k + 1)));
      end
    end
    checkOutput("arith8_wb_count", 32'(evRes8.size()), 32'd3);
    if (evRes8.size() == 3) begin
      for (int k = 0; k < 3; k++) checkOutput("arith8_result", evRes8[k], expRes8[k]);
    end
    checkOutput("arith_halt_cycle", 32'(haltCyc), 32'd8);
    checkOutput("arith_halted", 32'(halted16), 32'd1);
    checkOutput("arith_busy", 32'(busy16), 32'd0);
    checkOutput("arith_pc", 32'(pc16), 32'd3);
  endtask

  task automatic loadArith();
    loadWord(4'd0, 16'h2205);
    loadWord(4'd1, 16'h243D);
    loadWord(4'd2, 16'h0650);
    loadWord(4'd3, 16'hF000);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_result"}, 32'(result16), 32'd0);
    checkOutput({tag, "_wb_valid"}, 32'(wbValid16), 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(wbRd16), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc16), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy16), 32'd0);
    checkOutput({tag, "_halted"}, 32'(halted16), 32'd0);
    checkOutput({tag, "_result8"}, 32'(result8), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; progWe = 1'b0; progAddr = '0; progData = '0;
    #12;
    checkIdleZero("reset");
    rst = 1'b0;
    step(); step(); step();
    checkIdleZero("post_reset");

    loadArith();
    applyStimulus(40, 1'b0);
    checkArith();

    // BEQ r0,r0,-1 branches onto itself forever.
    loadWord(4'd0, 16'h703F);
    pulseStart();
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("loop_pc", 32'(pc16), 32'd0);
      checkOutput("loop_busy", 32'(busy16), 32'd1);
      checkOutput("loop_wb_valid", 32'(wbValid16), 32'd0);
    end
    rst = 1'b1; step(); rst = 1'b0; step();
    checkOutput("loop_reset_busy", 32'(busy16), 32'd0);

    loadWord(4'd15, 16'h2E07);
    loadWord(4'd0, 16'h2007);
    loadWord(4'd1, 16'h0200);
    loadWord(4'd2, 16'hF000);
    applyStimulus(40, 1'b0);
    checkOutput("r0_wb_count", 32'(evRes.size()), 32'd2);
    if (evRes.size() == 2) begin
      checkOutput("r0_write_result", evRes[0], 32'd7);
      checkOutput("r0_write_rd", evRd[0], 32'd0);
      checkOutput("r0_read_result", evRes[1], 32'd0);
      checkOutput("r0_read_rd", evRd[1], 32'd1);
    end
    checkOutput("r0_halt_cycle", 32'(haltCyc), 32'd6);
    checkOutput("r0_halt_pc", 32'(pc16), 32'd2);

    loadWord(4'd0, 16'h800F);
    pulseStart();
    step(); step();
    checkOutput("jmp_pc", 32'(pc16), 32'd15);
    checkOutput("jmp_wb_valid", 32'(wbValid16), 32'd0);
    step(); step();
    checkOutput("wrap_wb_valid", 32'(wbValid16), 32'd1);
    checkOutput("wrap_result", 32'(result16), 32'd7);
    checkOutput("wrap_wb_rd", 32'(wbRd16), 32'd7);
    checkOutput("wrap_pc", 32'(pc16), 32'd0);
    step(); step();
    checkOutput("rejmp_pc", 32'(pc16), 32'd15);
    checkOutput("rejmp_busy", 32'(busy16), 32'd1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Reset lands in the EXEC of the second instruction, after the first write-back.
    loadArith();
    pulseStart();
    step(); step(); step();
    checkOutput("pre_reset_result", 32'(result16), 32'd5);
    rst = 1'b1;
    #1;
    checkIdleZero("mid_reset");
    step();
    rst = 1'b0;
    step();
    applyStimulus(40, 1'b0);
    checkArith();

    applyStimulus(40, 1'b1);
    checkArith();
    applyStimulus(40, 1'b0);
    checkArith();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
